store_rmw_controller: RTL
=========================

Name: store_rmw_controller

Overview:
Multicycle sequencer for sb/sh/sw stores. It owns the memory port during a store and performs a read-modify-write for byte and halfword stores. It merges store data into the word read from memory, using the team's store-merge convention (byte → bits [7:0], half → bits [15:0], rest kept from memory). Word stores skip the read. It sits between the main control unit (start/done handshake) and the synchronous data memory.

Parameters:
READ_LAT, 1, memory read latency in cycles from address valid to MemDataIn valid. Legal range 1–4.

Ports:
clk  input  1  system clock, rising-edge
reset  input  1  asynchronous, active-low reset
start  input  1  request a store. Sampled in IDLE only.
StoreControl  input  2  1=byte, 2=half, 3=word, 0=no-op. Latched on accepted start.
Address  input  32  byte address. Latched on accepted start.
RegB  input  32  store data. Latched on accepted start.
MemDataIn  input  32  memory read data
MemAddr  output  32  memory address
MemWrite  output  1  memory write strobe, one cycle
MemDataOut  output  32  memory write data
busy  output  1  high in every state except IDLE
done  output  1  one-cycle completion pulse
AddrError  output  1  one-cycle misalignment pulse, coincident with done

Behaviour:
- Reset (reset=0, async):
  - state=IDLE.
  - MemAddr, MemDataOut and the internal latches = 0.
  - MemWrite, busy, done, AddrError = 0.
  - Reset mid-operation aborts the operation immediately. MemWrite falls without waiting for clk. No partial write completes after reset.
- States: IDLE, READ, MERGE, WRITE, DONE. Transitions:
  - IDLE: on start=1, latch StoreControl, Address, RegB, and drive MemAddr=Address.
    - If the access is misaligned (half with Address[0]=1, or word with Address[1:0]≠0): go to DONE with the error flag set.
    - Else if the type is 0: go to DONE (no-op).
    - Else if word: go to WRITE.
    - Else (byte/half): go to READ, loading the latency counter with READ_LAT-1.
  - READ: MemWrite=0, MemAddr held. Decrement the counter each cycle. When the counter is 0, go to MERGE.
  - MERGE: capture the merged word.
    - Byte: {MemDataIn[31:8], RegB_l[7:0]}.
    - Half: {MemDataIn[31:16], RegB_l[15:0]}.
    - Next state: WRITE.
  - WRITE: MemWrite=1 for exactly one cycle.
    - MemDataOut = merged word, or RegB_l for word stores.
    - MemAddr = Address_l.
    - Next state: DONE.
  - DONE: done=1 for one cycle. AddrError=1 only if the error flag is set. Next state: IDLE.
- Latency from the start-accept edge to the done cycle:
  - Word store: 2 cycles.
  - Byte/half store: READ_LAT+3 cycles.
  - Misaligned access or no-op: 1 cycle.
- Misaligned accesses and no-ops never assert MemWrite and never enter READ.
- MemWrite is never asserted outside WRITE.
- MemDataOut holds its last value outside WRITE.
- start while busy=1 is ignored: no queueing, no effect on the latched operands.
- start in the DONE cycle is also ignored. start is accepted the following cycle, when the state is IDLE.
- Input changes after acceptance have no effect. All datapath values come from the latches.
- MemDataIn is sampled only in MERGE.
- busy: 1 from the cycle after acceptance through DONE inclusive. 0 in IDLE.

Test Plan:
1. Reset/async abort: assert reset=0 while in WRITE with MemWrite=1.
   - MemWrite, busy and done go to 0 before the next clk edge.
   - After release, state is IDLE.
2. sb with READ_LAT=1: Address=0x100, RegB=0xAABBCCDD, MemDataIn=0x11223344.
   - Exactly one write: MemWrite=1 once with MemAddr=0x100, MemDataOut=0x112233DD.
   - done appears 4 cycles after acceptance.
3. sh with READ_LAT=3: Address=0x204, RegB=0x0000BEEF, MemDataIn=0xCAFE1234.
   - MemDataOut=0xCAFEBEEF.
   - done appears 6 cycles after acceptance.
   - MemWrite=0 throughout READ.
4. sw: Address=0x008, RegB=0xDEADBEEF.
   - No READ state. MemWrite fires in the cycle after acceptance with MemDataOut=0xDEADBEEF.
   - done follows one cycle later.
5. Misaligned: sh at Address=0x003, then sw at Address=0x006.
   - Each gives done=1 and AddrError=1 in the cycle after acceptance.
   - MemWrite never asserts.
6. Busy rejection: during an sb operation, pulse start with StoreControl=3, RegB=0x0.
   - The in-flight write result is unchanged.
   - Exactly one MemWrite and one done occur.
   - The second request is not executed.

Source files
------------

// File: rtl/store_rmw_if.sv
// Bus bundle between the main control unit, the store sequencer and the data memory.
// Handshake: start is a request sampled only while busy=0 (IDLE); it is accepted on that clock edge,
// busy rises the following cycle, and done pulses for exactly one cycle to close the operation.
interface store_rmw_if;
  logic        start;
  logic [1:0]  StoreControl;
  logic [31:0] Address;
  logic [31:0] RegB;
  logic [31:0] MemDataIn;
  logic [31:0] MemAddr;
  logic        MemWrite;
  logic [31:0] MemDataOut;
  logic        busy;
  logic        done;
  logic        AddrError;

  modport slave (
    input  start, StoreControl, Address, RegB, MemDataIn,
    output MemAddr, MemWrite, MemDataOut, busy, done, AddrError
  );

  modport master (
    output start, StoreControl, Address, RegB, MemDataIn,
    input  MemAddr, MemWrite, MemDataOut, busy, done, AddrError
  );
endinterface

// File: rtl/store_rmw_controller.sv
// Store sequencer for sb/sh/sw: word stores write directly, byte/half stores read the
// target word, merge the low byte/half of the store data into it and write it back.
module store_rmw_controller #(
  parameter int READ_LAT = 1
) (
  input  logic       clk,
  input  logic       reset,
  store_rmw_if.slave bus,
  output logic [2:0] dbg_state_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_MERGE = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [1:0] LAT_INIT = 2'(READ_LAT - 1);

  state_t      state_q, state_d;
  logic [1:0]  sc_q, sc_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic [31:0] mdo_q, mdo_d;
  logic        err_q, err_d;
  logic        misaligned;
  logic [31:0] keep_mask;

  always_comb begin
    misaligned = ((bus.StoreControl == 2'd2) && bus.Address[0]) ||
                 ((bus.StoreControl == 2'd3) && (bus.Address[1:0] != 2'b00));
  end

  // Bits set in keep_mask come from memory; the rest come from the store data.
  always_comb begin
    keep_mask = (sc_q == 2'd1) ? 32'hFFFF_FF00 : 32'hFFFF_0000;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      sc_q    <= 2'd0;
      cnt_q   <= 2'd0;
      addr_q  <= 32'd0;
      data_q  <= 32'd0;
      mdo_q   <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sc_q    <= sc_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      mdo_q   <= mdo_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sc_d    = sc_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    mdo_d   = mdo_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          sc_d   = bus.StoreControl;
          addr_d = bus.Address;
          data_d = bus.RegB;
          err_d  = misaligned;
          if (misaligned || (bus.StoreControl == 2'd0)) begin
            state_d = S_DONE;
          end else if (bus.StoreControl == 2'd3) begin
            state_d = S_WRITE;
          end else begin
            cnt_d   = LAT_INIT;
            state_d = S_READ;
          end
        end
      end
      S_READ: begin
        if (cnt_q == 2'd0) begin
          state_d = S_MERGE;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      S_MERGE: begin
        // The merged word replaces the latched store data so WRITE has a single source.
        data_d  = (bus.MemDataIn & keep_mask) | (data_q & ~keep_mask);
        state_d = S_WRITE;
      end
      S_WRITE: begin
        mdo_d   = data_q;
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Strobes decode straight from the state register so an async reset drops them at once.
  always_comb begin
    bus.MemAddr    = addr_q;
    bus.MemWrite   = (state_q == S_WRITE);
    bus.MemDataOut = (state_q == S_WRITE) ? data_q : mdo_q;
    bus.busy       = (state_q != S_IDLE);
    bus.done       = (state_q == S_DONE);
    bus.AddrError  = (state_q == S_DONE) && err_q;
    dbg_state_o    = state_q;
  end

endmodule
